// File: rtl/layer5_feeder.sv
`default_nettype none
// ============================================================================
// Module   : layer5_feeder
// Brief    : Layer-5 FC sequencer. Per neuron it clears the MAC PE, loads the
//            bias, streams N_IN operand pairs and returns the result on a
//            valid/ready port. Optional checker: LAYER5_FEEDER_CHECK_EN.
// Revision : 1.0
// ============================================================================
module layer5_feeder #(
   parameter int N_IN  = 84,
   parameter int N_OUT = 10,
   parameter int XAW   = 7,
   parameter int WAW   = 10,
   parameter int IW    = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   output logic           busy,
   output logic [XAW-1:0] x_addr,
   input  logic [15:0]    x_data,
   output logic [WAW-1:0] w_addr,
   input  logic [15:0]    w_data,
   output logic [IW-1:0]  b_addr,
   input  logic [15:0]    b_data,
   output logic           pe_clr,
   output logic [15:0]    pe_din1,
   output logic [15:0]    pe_din2,
   output logic [15:0]    pe_bias,
   output logic           pe_ena,
   input  logic [17:0]    pe_dout,
   input  logic           pe_finish,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [17:0]    res_data,
   output logic [IW-1:0]  res_idx,
   output logic           done,
   output logic           err
);

   localparam logic [XAW:0]  K_END  = (XAW+1)'(N_IN);
   localparam logic [IW-1:0] LAST_J = IW'(N_OUT - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CLEAR    = 3'd1,
      S_FETCH    = 3'd2,
      S_WAIT_FIN = 3'd3,
      S_OUT      = 3'd4
   } state_t;

   state_t         state, next_state;
   logic [XAW:0]   k;
   logic [WAW-1:0] wptr;
   logic [IW-1:0]  j;
   logic           data_valid;
   logic           bias_load;
   logic           timeout;
   logic           last_neuron;
   logic           out_accept;
   logic           capture;

   assign last_neuron = (j == LAST_J);
   assign out_accept  = (state == S_OUT) && res_ready;
   assign capture     = (state == S_WAIT_FIN) && (pe_finish || timeout);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:     if (start) next_state = S_CLEAR;
         S_CLEAR:    next_state = S_FETCH;
         S_FETCH:    if (k == K_END) next_state = S_WAIT_FIN;
         S_WAIT_FIN: if (pe_finish || timeout) next_state = S_OUT;
         S_OUT:      if (res_ready) next_state = last_neuron ? S_IDLE : S_CLEAR;
         default:    next_state = S_IDLE;
      endcase
   end

   // Operands follow addresses by one cycle (memory) plus one (din register).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy       <= 1'b0;
         x_addr     <= '0;
         w_addr     <= '0;
         b_addr     <= '0;
         pe_clr     <= 1'b0;
         pe_din1    <= '0;
         pe_din2    <= '0;
         pe_bias    <= '0;
         pe_ena     <= 1'b0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_idx    <= '0;
         done       <= 1'b0;
         j          <= '0;
         k          <= '0;
         wptr       <= '0;
         data_valid <= 1'b0;
         bias_load  <= 1'b0;
      end else begin
         pe_clr     <= (next_state == S_CLEAR);
         res_valid  <= (next_state == S_OUT);
         done       <= out_accept && last_neuron;
         data_valid <= (state == S_FETCH);
         pe_ena     <= data_valid;
         bias_load  <= (state == S_CLEAR);

         if (data_valid) begin
            pe_din1 <= x_data;
            pe_din2 <= w_data;
         end
         if (bias_load) pe_bias <= b_data;

         if (state == S_IDLE && start) busy <= 1'b1;

         if (next_state == S_CLEAR) begin
            k      <= '0;
            b_addr <= out_accept ? j + IW'(1) : j;
         end

         if (next_state == S_FETCH) begin
            x_addr <= k[XAW-1:0];
            w_addr <= wptr;
            k      <= k + (XAW+1)'(1);
            wptr   <= wptr + WAW'(1);
         end

         if (capture) begin
            res_data <= pe_finish ? pe_dout : '0;
            res_idx  <= j;
         end

         if (out_accept) begin
            if (last_neuron) begin
               j    <= '0;
               wptr <= '0;
               busy <= 1'b0;
            end else begin
               j <= j + IW'(1);
            end
         end
      end
   end

`ifdef LAYER5_FEEDER_CHECK_EN
   logic [XAW:0] ena_cnt;
   logic [4:0]   wait_cnt;
   logic         fin_q;

   assign timeout = (state == S_WAIT_FIN) && !pe_finish && (wait_cnt == 5'd16);

   // Only a rising finish is judged: a PE may hold finish until its next clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ena_cnt  <= '0;
         wait_cnt <= '0;
         fin_q    <= 1'b0;
         err      <= 1'b0;
      end else begin
         fin_q <= pe_finish;
         if (state == S_CLEAR)  ena_cnt <= '0;
         else if (pe_ena)       ena_cnt <= ena_cnt + (XAW+1)'(1);
         if (state != S_WAIT_FIN) wait_cnt <= '0;
         else                     wait_cnt <= wait_cnt + 5'd1;
         if (pe_finish && !fin_q && (state != S_WAIT_FIN || ena_cnt != K_END))
            err <= 1'b1;
         if (timeout) err <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_layer5_feeder.sv
`default_nettype none
// Randomized bench for layer5_feeder: behavioural PE, synchronous memories,
// golden dot-product model and a per-result scoreboard.
module tb_layer5_feeder;

   localparam int N_IN  = 84;
   localparam int N_OUT = 10;
   localparam int XAW   = 7;
   localparam int WAW   = 10;
   localparam int IW    = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic res_ready = 1'b0;
   logic busy, pe_clr, pe_ena, res_valid, done, err, pe_finish;
   logic [XAW-1:0] x_addr;
   logic [WAW-1:0] w_addr;
   logic [IW-1:0]  b_addr, res_idx;
   logic signed [15:0] x_data, w_data, b_data, pe_din1, pe_din2, pe_bias;
   logic [17:0] pe_dout, res_data;

   logic signed [15:0] xmem [0:127];
   logic signed [15:0] wmem [0:1023];
   logic signed [15:0] bmem [0:15];

   int n_checks = 0;
   int n_errors = 0;
   int fin_at = N_IN;

   logic signed [31:0] pe_acc;
   int   pe_cnt;
   logic pe_fin;

   layer5_feeder #(.N_IN(N_IN), .N_OUT(N_OUT), .XAW(XAW), .WAW(WAW), .IW(IW)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy),
      .x_addr(x_addr), .x_data(x_data), .w_addr(w_addr), .w_data(w_data),
      .b_addr(b_addr), .b_data(b_data), .pe_clr(pe_clr), .pe_din1(pe_din1),
      .pe_din2(pe_din2), .pe_bias(pe_bias), .pe_ena(pe_ena), .pe_dout(pe_dout),
      .pe_finish(pe_finish), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_idx(res_idx), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      x_data <= xmem[x_addr];
      w_data <= wmem[w_addr];
      b_data <= bmem[b_addr];
   end

   // Behavioural MAC PE: finish rises after fin_at accumulations.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         pe_acc <= 0; pe_cnt <= 0; pe_fin <= 1'b0;
      end else if (pe_clr) begin
         pe_acc <= 0; pe_cnt <= 0; pe_fin <= 1'b0;
      end else if (pe_ena) begin
         pe_acc <= pe_acc + int'(pe_din1) * int'(pe_din2);
         pe_cnt <= pe_cnt + 1;
         if (pe_cnt + 1 == fin_at) pe_fin <= 1'b1;
      end
   end
   assign pe_finish = pe_fin;
   assign pe_dout   = 18'(pe_acc + int'(pe_bias));

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [17:0] golden(input int j);
      int s = int'(bmem[j]);
      for (int k = 0; k < N_IN; k++) s += int'(xmem[k]) * int'(wmem[j*N_IN + k]);
      return 18'(s);
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_ctl"},  {26'd0, busy, pe_clr, pe_ena, res_valid, done, err}, 0);
      check({tag, "_addr"}, {7'd0, x_addr, w_addr, b_addr, res_idx}, 0);
      check({tag, "_din"},  {pe_din1, pe_din2}, 0);
      check({tag, "_res"},  {pe_bias, res_data}, 0);
   endtask

   task automatic fill_directed();
      for (int k = 0; k < 128; k++)  xmem[k] = 16'(k);
      for (int a = 0; a < 1024; a++) wmem[a] = 16'(1000 + a);
      for (int i = 0; i < 16; i++)   bmem[i] = 16'($urandom_range(0, 400)) - 16'sd200;
   endtask

   task automatic fill_random();
      for (int k = 0; k < 128; k++)  xmem[k] = 16'($urandom);
      for (int a = 0; a < 1024; a++) wmem[a] = 16'($urandom);
      for (int i = 0; i < 16; i++)   bmem[i] = 16'($urandom);
   endtask

   task automatic run_pass(input int ready_pct, input int stall_idx, input int rogue_start, input bit timed);
      int nres = 0, ndone = 0, done_n = -1, ena_k = 0, bad = 0, stall_bad = 0, stall_left = 0;
      int first_ena = -1, last_ena = -1, first_val = -1;
      bit stalled = 1'b0;
      logic [17:0]    hold_d = '0;
      logic [XAW-1:0] hold_x = '0;
      logic [WAW-1:0] hold_w = '0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         if (n == 0) begin
            check("clr_c0", pe_clr, 1);
            check("busy_c0", busy, 1);
         end
         if (pe_clr) begin
            if (b_addr !== IW'(nres)) bad++;
            ena_k = 0;
         end
         if (pe_ena) begin
            if (ena_k >= N_IN || nres >= N_OUT) bad++;
            else if (pe_din1 !== xmem[ena_k] || pe_din2 !== wmem[nres*N_IN + ena_k] ||
                     pe_bias !== bmem[nres]) bad++;
            if (nres == 0) begin
               if (first_ena < 0) first_ena = n;
               last_ena = n;
            end
            ena_k++;
         end
         if (res_valid && first_val < 0) first_val = n;
         if (done) begin ndone++; done_n = n; end
         if (done_n >= 0 && n == done_n + 1) check("busy_drop", busy, 0);
         if (stall_left == 0 && !stalled && res_valid && nres == stall_idx) begin
            stalled = 1'b1; stall_left = 20;
            hold_d = res_data; hold_x = x_addr; hold_w = w_addr;
         end
         if (stall_left > 0) begin
            if (!res_valid || res_data !== hold_d || x_addr !== hold_x || w_addr !== hold_w ||
                pe_ena || pe_clr || res_idx !== IW'(stall_idx)) stall_bad++;
            stall_left--;
            res_ready = 1'b0;
         end else begin
            res_ready = ($urandom_range(0, 99) < ready_pct);
         end
         start = (n == rogue_start);
         if (res_valid && res_ready) begin
            if (nres < N_OUT) begin
               check("res_idx", res_idx, nres);
               check("res_data", res_data, golden(nres));
               check("ena_cnt", ena_k, N_IN);
            end else bad++;
            nres++;
         end
         if (done_n >= 0 && n == done_n + 2) break;
         @(negedge clk);
      end
      start = 1'b0; res_ready = 1'b0;
      check("n_res", nres, N_OUT);
      check("n_done", ndone, 1);
      check("data_path", bad, 0);
      if (stall_idx >= 0) check("stall_hold", stall_bad, 0);
      if (timed) begin
         check("first_ena", first_ena, 3);
         check("last_ena", last_ena, 86);
         check("first_valid", first_val, 88);
         check("done_cycle", done_n, 890);
      end
      check("err_clean", err, 0);
   endtask

   task automatic reset_mid();
      int guard = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (!(busy && x_addr == XAW'(40)) && guard < 300) begin
         @(negedge clk); guard++;
      end
      check("find_k40", guard < 300, 1);
      reset = 1'b1;
      @(negedge clk);
      check_zero("mid_rst");
      reset = 1'b0;
   endtask

   initial begin
      int act = 0;
      logic [XAW-1:0] x0;
      logic [WAW-1:0] w0;
      fill_random();
      repeat (3) @(negedge clk);
      check_zero("rst");
      reset = 1'b0;
      x0 = x_addr; w0 = w_addr;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (pe_ena || pe_clr || busy || x_addr !== x0 || w_addr !== w0) act++;
      end
      check("idle_quiet", act, 0);

      fill_directed(); run_pass(100, -1, 30, 1'b1);
      fill_random();   run_pass(60, -1, -1, 1'b0);
      fill_random();   run_pass(100, 3, 200, 1'b0);
      reset_mid();     run_pass(100, -1, 500, 1'b0);

`ifdef LAYER5_FEEDER_CHECK_EN
      begin
         int err_seen = 0, dropped = 0, guard = 0;
         fin_at = 50;
         res_ready = 1'b1;
         @(negedge clk); start = 1'b1;
         @(negedge clk); start = 1'b0;
         for (int n = 0; n < 3000; n++) begin
            if (err) err_seen = 1;
            else if (err_seen == 1) dropped++;
            if (done) break;
            @(negedge clk);
         end
         check("early_done", done, 1);
         check("err_early", err_seen, 1);
         check("err_sticky", dropped, 0);
         @(negedge clk);
         check("err_after", err, 1);
         reset = 1'b1; @(negedge clk); reset = 1'b0;
         fin_at = 100000;
         @(negedge clk); start = 1'b1;
         @(negedge clk); start = 1'b0;
         while (!res_valid && guard < 400) begin @(negedge clk); guard++; end
         check("to_valid", res_valid, 1);
         check("to_err", err, 1);
         check("to_data", res_data, 0);
         res_ready = 1'b0;
         reset = 1'b1; @(negedge clk); reset = 1'b0;
         fin_at = N_IN;
      end
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/layer5_feeder.md
Name: layer5_feeder

Overview:
Sequencer that drives the layer-5 fully-connected multiply-accumulate PE. For each output neuron it clears the PE, loads the bias, and streams N_IN activation/weight pairs from synchronous-read memories on the PE's din1/din2/ena interface. It then waits for the PE's finish, captures dout, and hands the result downstream on a valid/ready handshake. It sits between the layer-4 activation buffer, the layer-5 weight/bias ROMs, and the PE instance.

Parameters:
N_IN, 84, operand pairs per neuron; must equal the PE's internal terminal count
N_OUT, 10, neurons per layer pass
XAW, 7, activation address width
WAW, 10, weight address width; 2^WAW >= N_IN*N_OUT
IW, 4, neuron index / bias address width; 2^IW >= N_OUT

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse, begins a layer pass
busy  out  1  high from accepted start until done
x_addr  out  XAW  activation memory address
x_data  in  16  signed activation, valid one cycle after x_addr
w_addr  out  WAW  weight memory address
w_data  in  16  signed weight, valid one cycle after w_addr
b_addr  out  IW  bias memory address
b_data  in  16  signed bias, valid one cycle after b_addr
pe_clr  out  1  PE clear, wired to the PE reset
pe_din1  out  16  signed activation to PE
pe_din2  out  16  signed weight to PE
pe_bias  out  16  signed bias to PE, held for the whole neuron
pe_ena  out  1  PE accumulate strobe
pe_dout  in  18  signed PE result
pe_finish  in  1  PE completion flag
res_valid  out  1  result available
res_ready  in  1  downstream accepts the result
res_data  out  18  signed captured neuron result
res_idx  out  IW  neuron index of res_data
done  out  1  one-cycle pulse after the last result is accepted
err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset: all outputs 0. State is IDLE. Neuron j=0, pair counter k=0, weight pointer 0. Reset mid-operation aborts immediately. pe_clr is not pulsed by reset because the PE shares the same reset.
- All outputs are registered.
- IDLE: start=1 -> CLEAR and busy=1. start is ignored whenever busy=1.
- CLEAR (1 cycle): pe_clr=1, b_addr=j, k=0.
- FETCH (N_IN cycles): each cycle issue x_addr=k and w_addr=wptr, then k++ and wptr++.
  - wptr is a running counter that is never reset between neurons, so it equals j*N_IN+k. No multiplier.
  - b_data is latched into pe_bias in the first FETCH cycle.
- Operand pipeline: an address issued in cycle t returns data in t+1. The data is registered into pe_din1/pe_din2 at the end of t+1, and pe_ena=1 during t+2.
  - Exactly N_IN pe_ena pulses per neuron, in consecutive cycles.
- After the last address the block goes to WAIT_FIN, which allows 2 drain cycles before finish can arrive.
- WAIT_FIN: on pe_finish=1, capture pe_dout into res_data and j into res_idx -> OUT.
- OUT: res_valid=1. res_data and res_idx are held stable until res_ready=1.
  - On handshake: res_valid=0 and j++.
  - If j was N_OUT-1: done=1 for one cycle, busy=0 -> IDLE, wptr=0. Otherwise -> CLEAR.
- Timing with res_ready=1: relative to the CLEAR cycle at c0, pe_ena runs in c3..c86, pe_finish arrives in c87, and res_valid=1 in c88. Each neuron takes 89 cycles, so a full pass takes 890 cycles after start.
- Backpressure: while in OUT with res_ready=0, there are no address changes and no pe_ena or pe_clr activity.
- Arithmetic: the block only moves data; no width changes. res_data is pe_dout bit-exact.

Optional Feature:
- Macro LAYER5_FEEDER_CHECK_EN.
- Defined: the block counts pe_ena pulses per neuron. err is set, sticky until reset, in either case:
  - pe_finish=1 while the count is not N_IN, or pe_finish=1 outside WAIT_FIN;
  - WAIT_FIN lasts more than 16 cycles. In that case the block also forces res_data=0, res_valid=1 so the pass completes.
- Not defined: err is tied to 0, no counter is built, and WAIT_FIN waits indefinitely.

Test Plan:
1. Assert reset, then deassert -> every output is 0 and busy=0. Hold start=0 for 10 cycles -> no pe_ena and no address change.
2. Memories hold x[k]=k and w[a]=1000+a; use a stub PE that returns finish and dout=18'h00123 after 84 enas. Pulse start -> pe_clr in c0; 84 consecutive pe_ena in c3..c86 with din1=0..83 and din2=1000..1083; res_valid in c88 with res_data=0x00123 and res_idx=0.
3. Real PE, res_ready tied to 1, full pass -> 10 results with res_idx 0..9, each equal to the golden model. Neuron 9 sees w_addr 756..839. done pulses once, 890 cycles after start; busy then drops.
4. Hold res_ready=0 for 20 cycles at neuron 3 -> res_valid stays 1, res_data is stable, and x_addr, w_addr, pe_ena and pe_clr are frozen. Releasing res_ready resumes with the CLEAR of neuron 4.
5. Assert reset at the FETCH cycle where k=40 -> all outputs are 0 next cycle. A new start gives a clean pass with 84 enas per neuron and w_addr restarting at 0. Also pulse start while busy -> ignored.
6. With LAYER5_FEEDER_CHECK_EN defined, the stub PE asserts finish after 50 enas -> err=1, and it stays 1 through the rest of the pass. With a stub PE that never finishes -> err=1 after 16 WAIT_FIN cycles, and res_data=0 with res_valid=1.
